lock_controller: RTL
====================

# lock_controller

Sequencing FSM for the three-digit lock. Collects BCD digits from the keypad, compares the entered code against the 12-bit passcode register output, and drives the register's load path when the user reprograms the code. Counts failed attempts and enforces a timed lockout. Sits between the keypad decoder and the passcode register.

## Interface
- DIGIT_W, 4, bits per digit (BCD)
- NUM_DIGITS, 3, digits per code; CODE_W = DIGIT_W*NUM_DIGITS = 12
- MAX_TRIES, 3, consecutive failures that trigger lockout (range 1..7)
- LOCKOUT_CYCLES, 16, lockout duration in clocks (≥1)
- OPEN_CYCLES, 32, auto-relock timeout in OPEN (≥1)

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- digit_in  in  4  keypad digit, valid when digit_valid=1
- digit_valid  in  1  one-cycle strobe per key press
- enter  in  1  one-cycle strobe: submit, relock or commit
- prog_req  in  1  one-cycle strobe: start reprogramming (OPEN only)
- stored_code  in  12  passcode register Q[11:0]
- load_code  out  12  passcode register P[11:0]
- load_en  out  1  passcode register selection line, 1 = load P, 0 = hold
- unlocked  out  1  lock open
- prog_mode  out  1  new-code entry in progress
- locked_out  out  1  lockout active, all inputs ignored
- digit_count  out  2  digits held in entry buffer (0..3)
- fail_count  out  3  consecutive failed attempts

## Operation
- Entry buffer: 12 bits. On each accepted digit: buf <= {buf[7:0], digit_in}. The first digit ends in [11:8]. digit_count saturates at 3. Digits beyond the third are ignored. Digits >9 are ignored and not counted.
- States: IDLE, ENTRY, CHECK, OPEN, PROG, WRITE, LOCKOUT.
- IDLE: locked, buffer and count are 0. An accepted digit loads the buffer, sets count=1 and moves to ENTRY. enter in IDLE is ignored.
- ENTRY: accepts digits. enter moves to CHECK. A short entry (count<3) always mismatches.
- CHECK (1 cycle): a match requires count==3 and buf==stored_code.
  - Match: go to OPEN and clear fail_count.
  - Mismatch: increment fail_count. If it reaches MAX_TRIES, go to LOCKOUT; otherwise go to IDLE.
  - The buffer is cleared on exit in both cases.
- OPEN: unlocked=1.
  - enter, or OPEN_CYCLES elapsed, moves to IDLE.
  - prog_req moves to PROG with the buffer cleared and the timer stopped.
  - Digits are ignored.
- PROG: prog_mode=1, collects digits as in ENTRY.
  - enter with count==3 moves to WRITE.
  - enter with count<3 aborts to OPEN with no write. The OPEN timer restarts.
- WRITE (1 cycle): load_en=1 and load_code=buf, then go to OPEN with the timer restarted. load_code is 0 whenever load_en=0.
- LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES clocks, then go to IDLE with fail_count cleared. digit_valid, enter and prog_req are discarded.
- Simultaneous events:
  - enter beats digit_valid in the same cycle; the digit is discarded.
  - enter beats prog_req in OPEN.
  - Timeout beats prog_req in the same cycle.
- Reset mid-operation, including during LOCKOUT or WRITE: return to IDLE with every counter and output at 0. A WRITE cut off by reset does not count as a write.

## Timing
- All outputs are registered. Reset values: every output is 0 and the state is IDLE.
- Unlock: enter sampled at edge k → CHECK during k..k+1 → unlocked=1 from edge k+2.
- Fail into lockout: locked_out=1 from edge k+2, held for LOCKOUT_CYCLES cycles.
- Commit: enter at edge k → load_en=1 for the single cycle after edge k+1. The register captures at edge k+2, and stored_code shows the new value from edge k+2.
- Auto-relock: unlocked falls OPEN_CYCLES cycles after entering OPEN.
- digit_count updates one cycle after digit_valid is sampled.

## Structure
- Shared package lock_pkg holds:
  - the state enum
  - DIGIT_W, NUM_DIGITS and CODE_W
  - BCD_MAX=9
- Sub-module lock_timer: a loadable down-counter with a done pulse. It is used for both LOCKOUT_CYCLES and OPEN_CYCLES; only one is active at a time.

## Test plan
- Reset, stored_code=0x123, enter digits 1,2,3 then enter → unlocked=1 two cycles after enter, fail_count=0.
- Digits 1,2,4 then enter, repeated 3× → fail_count goes 1, 2, then locked_out=1 for 16 cycles. Digits sent during lockout are ignored; afterwards state is IDLE with fail_count=0.
- In OPEN: prog_req, digits 9,8,7, enter → load_en pulses 1 cycle with load_code=0x987, then OPEN. After relock, digits 9,8,7 then enter unlocks.
- Edge cases: digits 1,2 then enter → mismatch. Digits 1,2,3,4 then enter → match on 0x123 (fourth digit ignored). Digit 0xA → count unchanged. enter and digit in the same cycle → digit discarded.
- Idle in OPEN for 32 cycles → unlocked drops. prog_req in the same cycle as the timeout → IDLE, no PROG.
- Assert Reset during LOCKOUT and during WRITE → all outputs 0 immediately, and load_en never completes its pulse.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the three-digit BCD lock.
package lock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int CODE_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_PROG,
    S_WRITE,
    S_LOCKOUT
  } state_t;

  // True for a legal keypad digit (0..9).
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad and passcode-register signals seen by the lock controller.
interface lock_controller_if;
  import lock_pkg::*;

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid;
  logic               enter;
  logic               prog_req;
  logic [CODE_W-1:0]  stored_code;
  logic [CODE_W-1:0]  load_code;
  logic               load_en;
  logic               unlocked;
  logic               prog_mode;
  logic               locked_out;
  logic [1:0]         digit_count;
  logic [2:0]         fail_count;

  // Keypad / register side
  modport master (
    output digit_in, digit_valid, enter, prog_req, stored_code,
    input  load_code, load_en, unlocked, prog_mode, locked_out, digit_count, fail_count
  );

  // Controller side
  modport slave (
    input  digit_in, digit_valid, enter, prog_req, stored_code,
    output load_code, load_en, unlocked, prog_mode, locked_out, digit_count, fail_count
  );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter; done pulses during the last running cycle.
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load wins over counting; counter parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (run && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = run && !load && (cnt == W'(1));

endmodule

// File: rtl/lock_controller.sv
// Sequencing FSM for the three-digit lock: entry, check, open/relock,
// reprogramming of the passcode register and timed lockout.
module lock_controller
  import lock_pkg::*;
#(
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int OPEN_CYCLES    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  lock_controller_if.slave bus
);

  localparam int TMAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] OPEN_TV = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] LOCK_TV = TW'(LOCKOUT_CYCLES);
  localparam logic [2:0]    MAX_F   = 3'(MAX_TRIES);
  localparam logic [1:0]    FULL    = 2'(NUM_DIGITS);

  state_t            state, state_d;
  logic [CODE_W-1:0] code_buf, code_buf_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        fails_q, fails_d;

  logic              tmr_load, tmr_run, tmr_done;
  logic [TW-1:0]     tmr_val;

  logic              digit_ok, digit_take;
  logic [CODE_W-1:0] code_shift;
  logic [2:0]        fails_inc;

  logic              unlocked_q, prog_mode_q, locked_out_q, load_en_q;
  logic [CODE_W-1:0] load_code_q;

  assign digit_ok   = bus.digit_valid && is_bcd(bus.digit_in);
  assign digit_take = digit_ok && (cnt_q != FULL);
  assign code_shift = {code_buf[CODE_W-DIGIT_W-1:0], bus.digit_in};
  assign fails_inc  = fails_q + 3'd1;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .done     (tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state, buffer/counter updates and timer control.
  // enter always takes priority over a same-cycle digit.
  always_comb begin
    state_d    = state;
    code_buf_d = code_buf;
    cnt_d      = cnt_q;
    fails_d    = fails_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_run    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.enter && digit_ok) begin
          code_buf_d = code_shift;
          cnt_d      = 2'd1;
          state_d    = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (bus.enter) state_d = S_CHECK;
        else if (digit_take) begin
          code_buf_d = code_shift;
          cnt_d      = cnt_q + 2'd1;
        end
      end
      S_CHECK: begin
        code_buf_d = '0;
        cnt_d      = '0;
        tmr_load   = 1'b1;
        if (cnt_q == FULL && code_buf == bus.stored_code) begin
          fails_d = '0;
          tmr_val = OPEN_TV;
          state_d = S_OPEN;
        end else begin
          fails_d = fails_inc;
          if (fails_inc == MAX_F) begin
            tmr_val = LOCK_TV;
            state_d = S_LOCKOUT;
          end else begin
            tmr_load = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        // enter, then timeout, then prog_req
        tmr_run = 1'b1;
        if (bus.enter || tmr_done) state_d = S_IDLE;
        else if (bus.prog_req)     state_d = S_PROG;
      end
      S_PROG: begin
        if (bus.enter) begin
          if (cnt_q == FULL) state_d = S_WRITE;
          else begin
            code_buf_d = '0;
            cnt_d      = '0;
            tmr_load   = 1'b1;
            tmr_val    = OPEN_TV;
            state_d    = S_OPEN;
          end
        end else if (digit_take) begin
          code_buf_d = code_shift;
          cnt_d      = cnt_q + 2'd1;
        end
      end
      S_WRITE: begin
        code_buf_d = '0;
        cnt_d      = '0;
        tmr_load   = 1'b1;
        tmr_val    = OPEN_TV;
        state_d    = S_OPEN;
      end
      S_LOCKOUT: begin
        tmr_run = 1'b1;
        if (tmr_done) begin
          fails_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry buffer, digit count and failure count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_buf <= '0;
      cnt_q    <= '0;
      fails_q  <= '0;
    end else begin
      code_buf <= code_buf_d;
      cnt_q    <= cnt_d;
      fails_q  <= fails_d;
    end
  end

  // Registered status outputs, decoded from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unlocked_q   <= 1'b0;
      prog_mode_q  <= 1'b0;
      locked_out_q <= 1'b0;
      load_en_q    <= 1'b0;
      load_code_q  <= '0;
    end else begin
      unlocked_q   <= (state == S_OPEN);
      prog_mode_q  <= (state == S_PROG);
      locked_out_q <= (state == S_LOCKOUT);
      load_en_q    <= (state == S_WRITE);
      load_code_q  <= (state == S_WRITE) ? code_buf : '0;
    end
  end

  assign bus.unlocked    = unlocked_q;
  assign bus.prog_mode   = prog_mode_q;
  assign bus.locked_out  = locked_out_q;
  assign bus.load_en     = load_en_q;
  assign bus.load_code   = load_code_q;
  assign bus.digit_count = cnt_q;
  assign bus.fail_count  = fails_q;

endmodule
